simple_axi_arbiter: RTL and testbench

//  Shares one simple-AXI master port (write + read channels) between NUM_REQ requesters.

---
 rtl/simple_axi_arb_pkg.sv | 30 +++
 rtl/simple_axi_rr_arbiter.sv | 65 ++++++
 rtl/simple_axi_arbiter.sv | 98 +++++++++
 tb/tb_simple_axi_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_axi_arb_pkg.sv
// simple_axi_arb_pkg: shared sizes, channel state type and the round-robin pick function
// for simple_axi_arbiter.
//   NUM_REQ_DEF  default requester count
//   GRANT_W      grant index width for the default requester count
//   MAX_REQ      largest supported requester count
//   chan_state_e per-channel arbitration state {IDLE, BUSY}
//   rr_pick      first set valid bit scanning upward from ptr with wrap
package simple_axi_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int GRANT_W     = $clog2(NUM_REQ_DEF);
    localparam int MAX_REQ     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chan_state_e;

    // Candidates are visited from the farthest offset down to ptr itself, so the
    // nearest valid requester at or after ptr is the last (winning) assignment.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
        int idx;
        rr_pick = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            idx = (ptr + k) % n;
            if (k < n && valid[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/simple_axi_rr_arbiter.sv
// simple_axi_rr_arbiter: one channel's grant FSM; picks a requester in IDLE and
// locks it in BUSY until the final accepted beat.
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   i_valid    per-requester request
//   i_release  final beat accepted for the current grant
//   o_grant_q  registered grant index
//   o_busy     channel holds a grant
// Macro SIMPLE_AXI_ARB_FIXED_PRIO_EN: when defined the pointer stays at 0, giving
// fixed priority with the lowest index winning.
module simple_axi_rr_arbiter
    import simple_axi_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic               i_release,
    output logic [GW-1:0]      o_grant_q,
    output logic               o_busy
);

    chan_state_e   r_state, w_state_nxt;
    logic [GW-1:0] r_grant, w_grant_nxt;
    logic [GW-1:0] r_ptr, w_ptr_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A request raised during the release cycle is only seen once back in IDLE,
    // which yields exactly one idle cycle between bursts.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        if (r_state == IDLE) begin
            if (|i_valid) begin
                w_state_nxt = BUSY;
                w_grant_nxt = GW'(rr_pick(MAX_REQ'(i_valid), int'(r_ptr), NUM_REQ));
            end
        end else if (i_release) begin
            w_state_nxt = IDLE;
`ifdef SIMPLE_AXI_ARB_FIXED_PRIO_EN
            w_ptr_nxt   = '0;
`else
            w_ptr_nxt   = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
`endif
        end
    end

    assign o_grant_q = r_grant;
    assign o_busy    = (r_state == BUSY);

endmodule

// File: rtl/simple_axi_arbiter.sv
// simple_axi_arbiter: shares one simple-AXI master port between NUM_REQ requesters,
// write and read channels arbitrated independently with burst-locked grants.
//   clk_i, rst_n_i                        clock, asynchronous active-low reset
//   req_w*_i / req_wready_o, req_wlast_o  per-requester write side (flattened slices)
//   req_r*_i / req_rready_o, req_rlast_o  per-requester read side, req_rdata_o broadcast
//   m_w*_o / m_wready_i, m_wlast_i        converter write port
//   m_r*_o / m_rready_i, m_rlast_i, m_rdata_i  converter read port
// Macro SIMPLE_AXI_ARB_FIXED_PRIO_EN: fixed priority (lowest index) instead of round-robin.
module simple_axi_arbiter
    import simple_axi_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              req_wvalid_i,
    output logic [NUM_REQ-1:0]              req_wready_o,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0]   req_waddr_i,
    input  logic [NUM_REQ*AXI_DATA_W-1:0]   req_wdata_i,
    input  logic [NUM_REQ*AXI_DATA_W/8-1:0] req_wstrb_i,
    input  logic [NUM_REQ*LEN_W-1:0]        req_wlen_i,
    output logic [NUM_REQ-1:0]              req_wlast_o,
    input  logic [NUM_REQ-1:0]              req_rvalid_i,
    output logic [NUM_REQ-1:0]              req_rready_o,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0]   req_raddr_i,
    input  logic [NUM_REQ*LEN_W-1:0]        req_rlen_i,
    output logic [AXI_DATA_W-1:0]           req_rdata_o,
    output logic [NUM_REQ-1:0]              req_rlast_o,
    output logic                            m_wvalid_o,
    output logic [AXI_ADDR_W-1:0]           m_waddr_o,
    output logic [AXI_DATA_W-1:0]           m_wdata_o,
    output logic [AXI_DATA_W/8-1:0]         m_wstrb_o,
    output logic [LEN_W-1:0]                m_wlen_o,
    input  logic                            m_wready_i,
    input  logic                            m_wlast_i,
    output logic                            m_rvalid_o,
    output logic [AXI_ADDR_W-1:0]           m_raddr_o,
    output logic [LEN_W-1:0]                m_rlen_o,
    input  logic                            m_rready_i,
    input  logic                            m_rlast_i,
    input  logic [AXI_DATA_W-1:0]           m_rdata_i
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = AXI_DATA_W / 8;

    logic [GW-1:0] w_wgrant, w_rgrant;
    logic          w_wbusy, w_rbusy;
    logic          w_wrel, w_rrel;
    logic [NUM_REQ-1:0] w_wsel, w_rsel;

    assign w_wrel = w_wbusy & m_wready_i & m_wlast_i;
    assign w_rrel = w_rbusy & m_rready_i & m_rlast_i;

    simple_axi_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_warb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_valid   (req_wvalid_i),
        .i_release (w_wrel),
        .o_grant_q (w_wgrant),
        .o_busy    (w_wbusy)
    );

    simple_axi_rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rarb (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .i_valid   (req_rvalid_i),
        .i_release (w_rrel),
        .o_grant_q (w_rgrant),
        .o_busy    (w_rbusy)
    );

    // One-hot select of the granted requester, all-zero while the channel is idle,
    // so every demuxed response and every muxed request is gated by a single term.
    assign w_wsel = w_wbusy ? (NUM_REQ'(1) << w_wgrant) : '0;
    assign w_rsel = w_rbusy ? (NUM_REQ'(1) << w_rgrant) : '0;

    assign m_wvalid_o = |(w_wsel & req_wvalid_i);
    assign m_waddr_o  = w_wbusy ? req_waddr_i[w_wgrant*AXI_ADDR_W +: AXI_ADDR_W] : '0;
    assign m_wdata_o  = w_wbusy ? req_wdata_i[w_wgrant*AXI_DATA_W +: AXI_DATA_W] : '0;
    assign m_wstrb_o  = w_wbusy ? req_wstrb_i[w_wgrant*SW +: SW] : '0;
    assign m_wlen_o   = w_wbusy ? req_wlen_i[w_wgrant*LEN_W +: LEN_W] : '0;

    assign req_wready_o = m_wready_i ? w_wsel : '0;
    assign req_wlast_o  = m_wlast_i ? w_wsel : '0;

    assign m_rvalid_o = |(w_rsel & req_rvalid_i);
    assign m_raddr_o  = w_rbusy ? req_raddr_i[w_rgrant*AXI_ADDR_W +: AXI_ADDR_W] : '0;
    assign m_rlen_o   = w_rbusy ? req_rlen_i[w_rgrant*LEN_W +: LEN_W] : '0;

    assign req_rready_o = m_rready_i ? w_rsel : '0;
    assign req_rlast_o  = m_rlast_i ? w_rsel : '0;
    assign req_rdata_o  = w_rbusy ? m_rdata_i : '0;

endmodule

// File: tb/tb_simple_axi_arbiter.sv
// tb_simple_axi_arbiter: randomized bench for simple_axi_arbiter with a burst-level
// reference model of both channels and a bench-side converter.
module tb_simple_axi_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_wvalid_i, req_wready_o, req_wlast_o;
    logic [N*AW-1:0] req_waddr_i, req_raddr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N*SW-1:0] req_wstrb_i;
    logic [N*LW-1:0] req_wlen_i, req_rlen_i;
    logic [N-1:0]    req_rvalid_i, req_rready_o, req_rlast_o;
    logic [DW-1:0]   req_rdata_o;
    logic            m_wvalid_o, m_rvalid_o;
    logic [AW-1:0]   m_waddr_o, m_raddr_o;
    logic [DW-1:0]   m_wdata_o, m_rdata_i;
    logic [SW-1:0]   m_wstrb_o;
    logic [LW-1:0]   m_wlen_o, m_rlen_o;
    logic            m_wready_i, m_wlast_i, m_rready_i, m_rlast_i;

    simple_axi_arbiter #(.NUM_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_wvalid_i (req_wvalid_i),
        .req_wready_o (req_wready_o),
        .req_waddr_i  (req_waddr_i),
        .req_wdata_i  (req_wdata_i),
        .req_wstrb_i  (req_wstrb_i),
        .req_wlen_i   (req_wlen_i),
        .req_wlast_o  (req_wlast_o),
        .req_rvalid_i (req_rvalid_i),
        .req_rready_o (req_rready_o),
        .req_raddr_i  (req_raddr_i),
        .req_rlen_i   (req_rlen_i),
        .req_rdata_o  (req_rdata_o),
        .req_rlast_o  (req_rlast_o),
        .m_wvalid_o   (m_wvalid_o),
        .m_waddr_o    (m_waddr_o),
        .m_wdata_o    (m_wdata_o),
        .m_wstrb_o    (m_wstrb_o),
        .m_wlen_o     (m_wlen_o),
        .m_wready_i   (m_wready_i),
        .m_wlast_i    (m_wlast_i),
        .m_rvalid_o   (m_rvalid_o),
        .m_raddr_o    (m_raddr_o),
        .m_rlen_o     (m_rlen_o),
        .m_rready_i   (m_rready_i),
        .m_rlast_i    (m_rlast_i),
        .m_rdata_i    (m_rdata_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // channel 0 = write, channel 1 = read
    bit            vld  [2][N];
    bit            done [2][N];
    logic [AW-1:0] adr  [2][N];
    logic [LW-1:0] len  [2][N];
    logic [DW-1:0] wd   [N];
    logic [SW-1:0] ws   [N];
    logic [DW-1:0] rd;
    bit            busy [2];
    int            g    [2];
    int            ptr  [2];
    int            beat [2];
    bit            rdy  [2];
    bit            lst  [2];
    bit [N-1:0]    en   [2];
    int            lmin, lmax, rpct, qpct;

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_wvalid_i[i]           = vld[0][i];
            req_waddr_i[i*AW +: AW]   = adr[0][i];
            req_wlen_i[i*LW +: LW]    = len[0][i];
            req_wdata_i[i*DW +: DW]   = wd[i];
            req_wstrb_i[i*SW +: SW]   = ws[i];
            req_rvalid_i[i]           = vld[1][i];
            req_raddr_i[i*AW +: AW]   = adr[1][i];
            req_rlen_i[i*LW +: LW]    = len[1][i];
        end
        m_wready_i = rdy[0];
        m_wlast_i  = lst[0];
        m_rready_i = rdy[1];
        m_rlast_i  = lst[1];
        m_rdata_i  = rd;
    endtask

    task automatic check();
        logic [N-1:0] sw, sr;
        sw = busy[0] ? N'(1) << g[0] : '0;
        sr = busy[1] ? N'(1) << g[1] : '0;
        chk("m_wvalid", m_wvalid_o, busy[0] && vld[0][g[0]]);
        chk("m_waddr", m_waddr_o, busy[0] ? adr[0][g[0]] : '0);
        chk("m_wlen", m_wlen_o, busy[0] ? len[0][g[0]] : '0);
        chk("m_wdata", m_wdata_o, busy[0] ? wd[g[0]] : '0);
        chk("m_wstrb", m_wstrb_o, busy[0] ? ws[g[0]] : '0);
        chk("req_wready", req_wready_o, rdy[0] ? sw : '0);
        chk("req_wlast", req_wlast_o, lst[0] ? sw : '0);
        chk("m_rvalid", m_rvalid_o, busy[1] && vld[1][g[1]]);
        chk("m_raddr", m_raddr_o, busy[1] ? adr[1][g[1]] : '0);
        chk("m_rlen", m_rlen_o, busy[1] ? len[1][g[1]] : '0);
        chk("req_rready", req_rready_o, rdy[1] ? sr : '0);
        chk("req_rlast", req_rlast_o, lst[1] ? sr : '0);
        chk("req_rdata", req_rdata_o, busy[1] ? rd : '0);
        chk("rready_onehot0", 64'($onehot0(req_rready_o)), 64'd1);
    endtask

    // Burst-level view: a granted requester owns the channel until the converter
    // accepts beat number len; the next owner is the nearest requester at or after ptr.
    task automatic model();
        for (int c = 0; c < 2; c++) begin
            if (busy[c]) begin
                if (rdy[c] && lst[c]) begin
                    busy[c] = 0;
                    done[c][g[c]] = 1;
                    beat[c] = 0;
`ifndef SIMPLE_AXI_ARB_FIXED_PRIO_EN
                    ptr[c] = (g[c] + 1) % N;
`endif
                end else if (rdy[c]) begin
                    beat[c]++;
                end
            end else begin
                beat[c] = 0;
                for (int k = 0; k < N && !busy[c]; k++) begin
                    if (vld[c][(ptr[c] + k) % N]) begin
                        busy[c] = 1;
                        g[c] = (ptr[c] + k) % N;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin
                if (done[c][i]) begin
                    vld[c][i] = 0;
                    done[c][i] = 0;
                end else if (!vld[c][i] && en[c][i] && int'($urandom_range(99)) < qpct) begin
                    vld[c][i] = 1;
                    adr[c][i] = $urandom;
                    len[c][i] = LW'($urandom_range(lmax, lmin));
                end
            end
            rdy[c] = int'($urandom_range(99)) < rpct;
            lst[c] = busy[c] ? (beat[c] == int'(len[c][g[c]])) : 1'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            wd[i] = $urandom;
            ws[i] = SW'($urandom);
        end
        rd = $urandom;
        drive();
        #1 check();
        model();
    endtask

    task automatic run(input int cyc, input bit [N-1:0] ew, input bit [N-1:0] er,
                       input int lo, input int hi, input int rp, input int qp);
        en[0] = ew;
        en[1] = er;
        lmin = lo;
        lmax = hi;
        rpct = rp;
        qpct = qp;
        repeat (cyc) step();
    endtask

    task automatic mid_reset();
        int k = 0;
        en[0] = 4'b0001;
        en[1] = 4'b0001;
        lmin = 7;
        lmax = 7;
        rpct = 100;
        qpct = 100;
        while (!(busy[0] && beat[0] == 2) && k < 30) begin
            step();
            k++;
        end
        chk("rst_wait_beat2", 64'(k < 30), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_outputs_zero",
               64'({m_wvalid_o, m_rvalid_o, req_wready_o, req_rready_o, req_wlast_o, req_rlast_o,
                    |m_waddr_o, |m_wdata_o, |m_wstrb_o, |m_wlen_o, |m_raddr_o, |m_rlen_o,
                    |req_rdata_o}), 64'd0);
        for (int c = 0; c < 2; c++) begin
            busy[c] = 0;
            ptr[c] = 0;
            beat[c] = 0;
            en[c] = '0;
            for (int i = 0; i < N; i++) begin
                vld[c][i] = 0;
                done[c][i] = 0;
            end
        end
        drive();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            busy[c] = 0;
            g[c] = 0;
            ptr[c] = 0;
            beat[c] = 0;
            rdy[c] = 0;
            lst[c] = 0;
            en[c] = '0;
            for (int i = 0; i < N; i++) begin
                vld[c][i] = 0;
                done[c][i] = 0;
                adr[c][i] = '0;
                len[c][i] = '0;
            end
        end
        for (int i = 0; i < N; i++) begin
            wd[i] = '0;
            ws[i] = '0;
        end
        rd = '0;
        drive();
        repeat (3) @(negedge clk);
        #1 check();
        rst_n = 1'b1;
        run(14, 4'b0001, 4'b0000, 3, 3, 100, 100);
        run(20, 4'b0000, 4'b0000, 0, 0, 100, 100);
        run(20, 4'b1010, 4'b0000, 2, 2, 100, 100);
        run(20, 4'b0000, 4'b0000, 0, 0, 100, 100);
        run(30, 4'b0000, 4'b1111, 0, 0, 100, 100);
        run(20, 4'b0000, 4'b0000, 0, 0, 100, 100);
        run(40, 4'b0100, 4'b0001, 3, 5, 100, 100);
        run(20, 4'b0000, 4'b0000, 0, 0, 100, 100);
        mid_reset();
        run(30, 4'b1111, 4'b1111, 0, 3, 100, 100);
        run(30, 4'b0000, 4'b0000, 0, 0, 100, 100);
        run(30, 4'b0101, 4'b0101, 0, 2, 100, 100);
        run(2000, 4'b1111, 4'b1111, 0, 7, 70, 40);
        run(150, 4'b0000, 4'b0000, 0, 0, 70, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
